// File: rtl/prime_pkg.sv
// Shared constants and FSM encoding for the nth-prime finder and the prime scanner.
package prime_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 11;
  localparam int unsigned DEFAULT_IDX_WIDTH = 8;
  localparam int unsigned PRIME_MAX_VALUE   = 1000;

  typedef enum logic [2:0] {
    sIdle,
    sTest,
    sCheck,
    sMod,
    sNext,
    sDone
  } state_t;

endpackage

// File: rtl/mod_unit.sv
// Iterative restoring shift-subtract remainder; remainder valid with modDone, WIDTH+1 cycles
// after modStart. The divisor is never zero in this design.
module mod_unit
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             modStart,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remainder,
  output logic             modDone
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [CntW-1:0]  cnt_q;
  logic             active_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_nx;

  // Partial remainder stays below the divisor, so one extra bit covers the shift.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    rem_nx  = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, dsr_q}) begin
      rem_nx = WIDTH'(shifted - {1'b0, dsr_q});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      remainder <= '0;
      modDone   <= 1'b0;
    end else begin
      modDone <= 1'b0;
      if (modStart) begin
        dvd_q    <= dividend;
        dsr_q    <= divisor;
        rem_q    <= '0;
        cnt_q    <= CntW'(WIDTH);
        active_q <= 1'b1;
      end else if (active_q) begin
        dvd_q <= dvd_q << 1;
        rem_q <= rem_nx;
        cnt_q <= cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          active_q  <= 1'b0;
          remainder <= rem_nx;
          modDone   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nth_prime_finder.sv
// Finds the Nth prime by trial division over odd candidates up to MAX_VALUE.
// Optional prime stream outputs are enabled by defining PRIME_STREAM_EN.
module nth_prime_finder
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned IDX_WIDTH = DEFAULT_IDX_WIDTH,
  parameter int unsigned MAX_VALUE = PRIME_MAX_VALUE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] nTarget,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     nthPrime,
  output logic                 notFound,
  output logic [WIDTH-1:0]     candidate,
  output logic [IDX_WIDTH-1:0] primesFound
`ifdef PRIME_STREAM_EN
  ,
  output logic                 primeStrobe,
  output logic [WIDTH-1:0]     primeValue
`endif
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VALUE);

  state_t               state;
  logic [IDX_WIDTH-1:0] target;
  logic [WIDTH-1:0]     divisor;
  logic                 mod_start;
  logic [WIDTH-1:0]     remainder;
  logic                 mod_done;
  logic [IDX_WIDTH-1:0] count_inc;
  logic [2*WIDTH-1:0]   div_sq;
  logic [WIDTH-1:0]     next_cand;
  logic                 found_prime;

  mod_unit #(
    .WIDTH(WIDTH)
  ) u_mod (
    .clk      (clk),
    .rst      (rst),
    .modStart (mod_start),
    .dividend (candidate),
    .divisor  (divisor),
    .remainder(remainder),
    .modDone  (mod_done)
  );

  always_comb begin
    count_inc   = primesFound + IDX_WIDTH'(1);
    div_sq      = {{WIDTH{1'b0}}, divisor} * {{WIDTH{1'b0}}, divisor};
    next_cand   = (candidate == WIDTH'(2)) ? WIDTH'(3) : candidate + WIDTH'(2);
    found_prime = ((state == sTest) && (candidate == WIDTH'(2))) ||
                  ((state == sCheck) && (div_sq > {{WIDTH{1'b0}}, candidate}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= sIdle;
      target      <= '0;
      divisor     <= '0;
      mod_start   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      nthPrime    <= '0;
      notFound    <= 1'b0;
      candidate   <= '0;
      primesFound <= '0;
`ifdef PRIME_STREAM_EN
      primeStrobe <= 1'b0;
      primeValue  <= '0;
`endif
    end else begin
      done      <= 1'b0;
      mod_start <= 1'b0;
`ifdef PRIME_STREAM_EN
      primeStrobe <= 1'b0;
`endif
      if (found_prime) begin
        primesFound <= count_inc;
`ifdef PRIME_STREAM_EN
        primeStrobe <= 1'b1;
        primeValue  <= candidate;
`endif
        if (count_inc == target) begin
          nthPrime <= candidate;
          state    <= sDone;
        end else begin
          state <= sNext;
        end
      end else begin
        unique case (state)
          sIdle: begin
            if (start) begin
              target      <= nTarget;
              busy        <= 1'b1;
              nthPrime    <= '0;
              notFound    <= 1'b0;
              primesFound <= '0;
              if (nTarget == '0) begin
                notFound <= 1'b1;
                state    <= sDone;
              end else begin
                candidate <= WIDTH'(2);
                state     <= sTest;
              end
            end
          end
          sTest: begin
            divisor <= WIDTH'(3);
            state   <= sCheck;
          end
          sCheck: begin
            mod_start <= 1'b1;
            state     <= sMod;
          end
          sMod: begin
            if (mod_done) begin
              if (remainder == '0) begin
                state <= sNext;
              end else begin
                divisor <= divisor + WIDTH'(2);
                state   <= sCheck;
              end
            end
          end
          sNext: begin
            if (next_cand > MaxVal) begin
              notFound <= 1'b1;
              nthPrime <= '0;
              state    <= sDone;
            end else begin
              candidate <= next_cand;
              state     <= sTest;
            end
          end
          sDone: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= sIdle;
          end
          default: state <= sIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/nth_prime_finder.md
Name: nth_prime_finder

Overview:
- Inverse of the team's prime scanner. The scanner maps an upper bound to a prime count; this block maps a prime index N to the Nth prime.
- It uses true trial division instead of a lookup table, so candidates are not limited to a hard-coded list.
- It sits beside the scanner in the exercise top level and is driven by a start/done handshake from the test controller.

Parameters:
- WIDTH, 11, bit width of candidate, divisor and result values.
- IDX_WIDTH, 8, bit width of nTarget and primesFound.
- MAX_VALUE, 1000, largest candidate examined; searching past it aborts with notFound.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in sIdle
- nTarget  input  IDX_WIDTH  index N of the requested prime (1 gives 2)
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the result is valid
- nthPrime  output  WIDTH  result; 0 if notFound
- notFound  output  1  N is 0, or the Nth prime exceeds MAX_VALUE
- candidate  output  WIDTH  number currently under test
- primesFound  output  IDX_WIDTH  running prime count for the current request

Behaviour:
- Fixed: one clock, clk; synchronous active-high reset, rst.
- Reset: all outputs are 0 and state is sIdle. Asserting rst mid-operation aborts the search and clears all outputs on the next edge.
- State sIdle:
  - busy=0.
  - start=1 latches nTarget.
  - If nTarget==0, go to sDone with notFound=1.
  - Otherwise set candidate=2, primesFound=0 and go to sTest.
- State sTest:
  - If candidate==2, the candidate is prime.
  - Otherwise set divisor=3 and go to sCheck.
- State sCheck:
  - If divisor*divisor > candidate (computed at 2*WIDTH bits, no truncation), the candidate is prime.
  - Otherwise pulse modStart and go to sMod.
- State sMod:
  - Wait for modDone.
  - remainder==0: the candidate is composite.
  - Otherwise divisor += 2 and return to sCheck.
- Prime handling:
  - primesFound increments.
  - If the new count == nTarget, set nthPrime=candidate and go to sDone.
  - Otherwise go to sNext.
- Composite handling: go to sNext.
- State sNext:
  - Next candidate is 3 after 2; otherwise candidate + 2. Even numbers above 2 are never tested.
  - If the next candidate > MAX_VALUE, go to sDone with notFound=1 and nthPrime=0; primesFound keeps its final count.
- State sDone: done=1 for exactly one cycle, then sIdle.
- Result holding: nthPrime, notFound and primesFound hold until the next accepted start, which clears them in the accept cycle.
- start while busy is ignored; the latched nTarget is not changed.
- start in the same cycle as rst: rst wins.
- Latency: not fixed, data dependent. Each modulo takes WIDTH+1 cycles.

Optional Feature:
- Macro: PRIME_STREAM_EN.
- Defined: adds output primeStrobe (1 bit) and primeValue (WIDTH bits).
  - primeStrobe pulses for one cycle on every prime found.
  - primeValue equals that prime and holds until the next strobe.
  - The output stream matches the scanner's prime sequence.
- Undefined: these ports and their logic are absent; core behaviour is unchanged.

Decomposition:
- Shared package prime_pkg:
  - state encoding: sIdle, sTest, sCheck, sMod, sNext, sDone;
  - default WIDTH/IDX_WIDTH;
  - MAX_VALUE constant, shared with the scanner.
- Sub-module mod_unit: iterative shift-subtract remainder.
  - Ports: clk, rst, modStart, dividend, divisor → remainder, modDone.
  - Fixed latency WIDTH+1 cycles.
  - Divisor 0 never occurs, since the divisor is always ≥3.

Test Plan:
- Reset, start with nTarget=1 → done within 5 cycles, nthPrime=2, primesFound=1, notFound=0.
- nTarget=10 → nthPrime=29, primesFound=10; candidate never shows an even value above 2.
- nTarget=168 → nthPrime=997. Then nTarget=169 → notFound=1, nthPrime=0, primesFound=168.
- nTarget=0 → done exactly 2 cycles after start, notFound=1, nthPrime=0.
- Start nTarget=100, assert rst for 1 cycle mid-run → all outputs 0 next cycle. Then start nTarget=25 → nthPrime=97.
- Start nTarget=5, pulse start with nTarget=50 while busy → ignored; result nthPrime=11. With PRIME_STREAM_EN, primeStrobe fires 5 times with values 2, 3, 5, 7, 11.
